// File: rtl/cic_decim_mc_if.sv
// cic_decim_mc_if
//   Output sample stream of the multi-channel CIC decimator.
//   Handshake: a word (out, out_ch, out_last) transfers on a rising clock
//   edge where out_valid && out_ready. The producer raises out_valid on its
//   own and keeps out/out_ch/out_last stable until that transfer happens.
//   out_ready may change at any time and has no effect while out_valid is low.
// Signals
//   out        signed filtered sample, ACC_W bits
//   out_ch     channel index of out
//   out_valid  out/out_ch/out_last hold a word
//   out_last   word belongs to the highest channel (end of frame)
//   out_ready  consumer accepts the word
// Modports
//   master     producer side (the decimator)
//   slave      consumer side
interface cic_decim_mc_if #(
   parameter int ACC_W = 32,
   parameter int CH_W  = 2
);
   logic signed [ACC_W-1:0] out;
   logic [CH_W-1:0]         out_ch;
   logic                    out_valid;
   logic                    out_last;
   logic                    out_ready;

   modport master (output out, out_ch, out_valid, out_last, input out_ready);
   modport slave  (input out, out_ch, out_valid, out_last, output out_ready);
endinterface

// File: rtl/cic_decim_mc.sv
// cic_decim_mc
//   Multi-channel CIC decimator for PDM microphone arrays. Every channel has
//   its own ORDER-stage integrator chain; a single comb engine is shared and
//   walks the channels one per cycle after each decimation point, emitting
//   full-precision samples tagged with their channel index.
// Ports
//   clk        clock
//   rst        synchronous active-low reset
//   clk_en     global enable, 0 freezes everything
//   new_data   PDM sample strobe (accepted when clk_en && new_data)
//   din        PDM bits, bit c = channel c, 1 -> +1, 0 -> -1
//   dec_num    decimation rate to load (0 is stored as 1)
//   dec_we     load dec_num and flush the filter
//   st         output stream (master modport of cic_decim_mc_if)
//   overrun    sticky: a decimation frame was dropped
//   dbg_state  FSM state, 1 = RUN (walking channels), 0 = IDLE
module cic_decim_mc #(
   parameter int NUM_CH      = 4,
   parameter int ORDER       = 4,
   parameter int DEC_W       = 16,
   parameter int DEC_DEFAULT = 64,
   parameter int ACC_W       = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_en,
   input  logic                 new_data,
   input  logic [NUM_CH-1:0]    din,
   input  logic [DEC_W-1:0]     dec_num,
   input  logic                 dec_we,
   cic_decim_mc_if.master       st,
   output logic                 overrun,
   output logic                 dbg_state
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [CH_W-1:0]   ch, ch_nxt;

   logic [DEC_W-1:0]  rate, cnt;
   logic [ACC_W-1:0]  integ     [NUM_CH][ORDER];
   logic [ACC_W-1:0]  integ_nxt [NUM_CH][ORDER];
   logic [ACC_W-1:0]  snap      [NUM_CH];
   logic [ACC_W-1:0]  dly       [NUM_CH][ORDER];
   logic [ACC_W-1:0]  comb_x    [ORDER];
   logic [ACC_W-1:0]  comb_y;

   logic flush, accept, dec_pt, last_ch, load, busy, take;

   assign flush     = clk_en && dec_we;
   // A rate load takes priority over a sample arriving on the same edge.
   assign accept    = clk_en && new_data && !dec_we;
   assign dec_pt    = accept && (cnt == rate - 1'b1);
   assign dbg_state = (state == RUN);

   // Integrator chains: stage k adds the freshly updated stage k-1.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         integ_nxt[c][0] = integ[c][0] + (din[c] ? ACC_W'(1) : {ACC_W{1'b1}});
         for (int k = 1; k < ORDER; k++)
            integ_nxt[c][k] = integ[c][k] + integ_nxt[c][k-1];
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         ch    <= '0;
      end else if (clk_en) begin
         state <= state_nxt;
         ch    <= ch_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      ch_nxt    = ch;
      if (flush) begin
         state_nxt = IDLE;
         ch_nxt    = '0;
      end else if (take) begin
         state_nxt = RUN;
         ch_nxt    = '0;
      end else if (load) begin
         if (last_ch) begin
            state_nxt = IDLE;
            ch_nxt    = '0;
         end else begin
            ch_nxt = ch + 1'b1;
         end
      end
   end

   // FSM: outputs / datapath controls
   always_comb begin
      last_ch = (ch == CH_W'(NUM_CH - 1));
      load    = clk_en && (state == RUN) && (!st.out_valid || st.out_ready);
      // The edge that loads the last channel frees the comb engine, so a
      // decimation point on that same edge still starts a new frame.
      busy    = (state == RUN) && !(load && last_ch);
      take    = dec_pt && !busy;
      comb_y  = snap[ch];
      for (int k = 0; k < ORDER; k++) begin
         comb_x[k] = comb_y;
         comb_y    = comb_y - dly[ch][k];
      end
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (!rst) begin
         rate         <= DEC_W'(DEC_DEFAULT);
         cnt          <= '0;
         overrun      <= 1'b0;
         st.out       <= '0;
         st.out_ch    <= '0;
         st.out_valid <= 1'b0;
         st.out_last  <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            snap[c] <= '0;
            for (int k = 0; k < ORDER; k++) begin
               integ[c][k] <= '0;
               dly[c][k]   <= '0;
            end
         end
      end else if (flush) begin
         rate         <= (dec_num == '0) ? DEC_W'(1) : dec_num;
         cnt          <= '0;
         overrun      <= 1'b0;
         st.out_valid <= 1'b0;
         st.out_last  <= 1'b0;
         for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < ORDER; k++) begin
               integ[c][k] <= '0;
               dly[c][k]   <= '0;
            end
      end else if (clk_en) begin
         if (accept) begin
            integ <= integ_nxt;
            cnt   <= dec_pt ? '0 : cnt + 1'b1;
         end
         if (take)
            for (int c = 0; c < NUM_CH; c++)
               snap[c] <= integ_nxt[c][ORDER-1];
         if (dec_pt && busy)
            overrun <= 1'b1;
         if (load) begin
            st.out       <= comb_y;
            st.out_ch    <= ch;
            st.out_valid <= 1'b1;
            st.out_last  <= last_ch;
            for (int k = 0; k < ORDER; k++)
               dly[ch][k] <= comb_x[k];
         end else if (state == IDLE && st.out_valid && st.out_ready) begin
            st.out_valid <= 1'b0;
            st.out_last  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_cic_decim_mc.sv
// tb_cic_decim_mc
//   Directed bench for cic_decim_mc (NUM_CH=2, ORDER=4). A behavioural CIC
//   model computes each frame when the decimating sample is driven and
//   queues the expected words; a monitor pops and compares on each transfer.
module tb_cic_decim_mc;
   localparam int NUM_CH = 2, ORDER = 4, DEC_W = 16, DEC_DEFAULT = 64, ACC_W = 32;
   localparam int CH_W = 1;
   localparam int W = ACC_W + CH_W + 1;

   logic              clk = 1'b0, rst = 1'b0, clk_en = 1'b0, new_data = 1'b0, dec_we = 1'b0;
   logic [NUM_CH-1:0] din = '0;
   logic [DEC_W-1:0]  dec_num = '0;
   logic              overrun, dbg_state;

   cic_decim_mc_if #(.ACC_W(ACC_W), .CH_W(CH_W)) sif ();

   cic_decim_mc #(.NUM_CH(NUM_CH), .ORDER(ORDER), .DEC_W(DEC_W),
                  .DEC_DEFAULT(DEC_DEFAULT), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .new_data(new_data), .din(din),
      .dec_num(dec_num), .dec_we(dec_we), .st(sif), .overrun(overrun),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0, n_out = 0;
   logic [W-1:0]     exp_q[$];
   logic [ACC_W-1:0] m_int [NUM_CH][ORDER];
   logic [ACC_W-1:0] m_dly [NUM_CH][ORDER];
   int unsigned      m_cnt, m_rate;
   bit               drop_mode = 0;
   logic [ACC_W-1:0] last_out [NUM_CH];
   logic [ACC_W-1:0] held;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // reference model
   task automatic model_clear(input int unsigned r);
      for (int c = 0; c < NUM_CH; c++)
         for (int k = 0; k < ORDER; k++) begin
            m_int[c][k] = '0;
            m_dly[c][k] = '0;
         end
      m_cnt  = 0;
      m_rate = r;
   endtask

   task automatic model_sample(input logic [NUM_CH-1:0] d);
      logic [ACC_W-1:0] x, y;
      for (int c = 0; c < NUM_CH; c++) begin
         m_int[c][0] = m_int[c][0] + (d[c] ? ACC_W'(1) : {ACC_W{1'b1}});
         for (int k = 1; k < ORDER; k++)
            m_int[c][k] = m_int[c][k] + m_int[c][k-1];
      end
      if (m_cnt == m_rate - 1) begin
         m_cnt = 0;
         if (!drop_mode)
            for (int c = 0; c < NUM_CH; c++) begin
               x = m_int[c][ORDER-1];
               for (int k = 0; k < ORDER; k++) begin
                  y = x - m_dly[c][k];
                  m_dly[c][k] = x;
                  x = y;
               end
               exp_q.push_back({(c == NUM_CH - 1), CH_W'(c), x});
            end
      end else begin
         m_cnt++;
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [NUM_CH-1:0] d, input logic nd);
      din = d;
      new_data = nd;
      if (rst && clk_en && nd && !dec_we) model_sample(d);
      step();
      new_data = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load_rate(input logic [DEC_W-1:0] r);
      dec_num = r;
      dec_we  = 1'b1;
      step();
      dec_we  = 1'b0;
      exp_q.delete();
      model_clear((r == 0) ? 1 : int'(r));
   endtask

   task automatic drain(input string tag);
      sif.out_ready = 1'b1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
      step();
      check({tag, "_drained"}, exp_q.size(), 0);
      check({tag, "_valid_low"}, sif.out_valid, 0);
   endtask

   // scoreboard monitor: a transfer happens at the next rising edge
   always @(negedge clk) begin
      if (rst && clk_en && !dec_we && sif.out_valid && sif.out_ready) begin
         logic [W-1:0] e;
         if (exp_q.size() == 0) begin
            n_checks++;
            $error("FAIL out_extra: observed ch%0d 0x%0h, expected no word",
                   sif.out_ch, sif.out);
         end else begin
            e = exp_q.pop_front();
            check("out_word", {sif.out_last, sif.out_ch, sif.out}, e);
         end
         last_out[sif.out_ch] = sif.out;
         n_out++;
      end
   end

   initial begin
      sif.out_ready = 1'b1;
      clk_en = 1'b1;
      rst = 1'b0;
      idle(3);
      check("rst_out",       sif.out, 0);
      check("rst_out_ch",    sif.out_ch, 0);
      check("rst_out_valid", sif.out_valid, 0);
      check("rst_out_last",  sif.out_last, 0);
      check("rst_overrun",   overrun, 0);
      rst = 1'b1;
      model_clear(DEC_DEFAULT);

      // default rate, random backpressure
      for (int i = 0; i < 2 * DEC_DEFAULT; i++) begin
         sif.out_ready = 1'($urandom_range(0, 1));
         drive(2'b11, 1'b1);
      end
      drain("default");
      check("default_frames", n_out, 2 * NUM_CH);

      // T1: R=3, DC +1 on both channels
      load_rate(3);
      for (int i = 0; i < 18; i++) drive(2'b11, 1'b1);
      drain("t1");
      check("t1_ch0", last_out[0], 81);
      check("t1_ch1", last_out[1], 81);

      // clk_en=0 freezes a stalled word, out_ready ignored
      sif.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) drive(2'b11, 1'b1);
      idle(2);
      held = sif.out;
      clk_en = 1'b0;
      sif.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) drive(2'b01, 1'b1);
      check("gate_out",   sif.out, held);
      check("gate_valid", sif.out_valid, 1);
      check("gate_ch",    sif.out_ch, 0);
      clk_en = 1'b1;
      drain("gate");
      check("gate_overrun", overrun, 0);

      // T2: ch0 DC +1, ch1 DC -1
      load_rate(3);
      for (int i = 0; i < 18; i++) drive(2'b01, 1'b1);
      drain("t2");
      check("t2_ch0", last_out[0], 81);
      check("t2_ch1", last_out[1], 32'hFFFF_FFAF);

      // T3: R=2, alternating input, back-to-back frames
      load_rate(2);
      for (int i = 0; i < 40; i++) drive((i % 2 == 0) ? 2'b11 : 2'b00, 1'b1);
      drain("t3");
      check("t3_ch0", last_out[0], 0);
      check("t3_ch1", last_out[1], 0);
      check("t3_overrun", overrun, 0);

      // T4: stall across two decimation points
      load_rate(3);
      for (int i = 0; i < 18; i++) drive(2'b11, 1'b1);
      drain("t4_pre");
      sif.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) drive(2'b11, 1'b1);
      drop_mode = 1;
      for (int i = 0; i < 2; i++) drive(2'b11, 1'b1);
      held = sif.out;
      check("t4_stall_ch0", held, 81);
      for (int i = 0; i < 4; i++) drive(2'b11, 1'b1);
      drop_mode = 0;
      check("t4_hold_out",   sif.out, held);
      check("t4_hold_ch",    sif.out_ch, 0);
      check("t4_hold_valid", sif.out_valid, 1);
      check("t4_overrun",    overrun, 1);
      n_out = 0;
      drain("t4");
      check("t4_words", n_out, NUM_CH);
      check("t4_overrun_sticky", overrun, 1);

      // T5: rate load in the middle of a frame
      for (int i = 0; i < 3; i++) drive(2'b11, 1'b1);
      idle(1);
      check("t5_mid_valid",   sif.out_valid, 1);
      check("t5_mid_overrun", overrun, 1);
      load_rate(16);
      check("t5_flush_valid",   sif.out_valid, 0);
      check("t5_flush_overrun", overrun, 0);
      check("t5_flush_state",   dbg_state, 0);
      for (int i = 0; i < 7 * 16; i++) drive(2'b11, 1'b1);
      drain("t5");
      check("t5_ch0", last_out[0], 65536);
      check("t5_ch1", last_out[1], 65536);

      // T6: reset mid-frame, then rate 0 behaves as R=1
      for (int i = 0; i < 16; i++) drive(2'b11, 1'b1);
      idle(1);
      check("t6_pre_valid", sif.out_valid, 1);
      rst = 1'b0;
      step();
      check("t6_rst_out",     sif.out, 0);
      check("t6_rst_out_ch",  sif.out_ch, 0);
      check("t6_rst_valid",   sif.out_valid, 0);
      check("t6_rst_last",    sif.out_last, 0);
      check("t6_rst_overrun", overrun, 0);
      rst = 1'b1;
      exp_q.delete();
      model_clear(DEC_DEFAULT);
      load_rate(0);
      for (int i = 0; i < 6; i++) begin
         drive(2'b11, 1'b1);
         idle(3);
      end
      drain("t6");
      check("t6_ch0", last_out[0], 1);
      check("t6_ch1", last_out[1], 1);
      check("t6_overrun", overrun, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
